// File: rtl/ov7670_config_seq.sv
// OV7670 register initialisation sequencer.
// Walks a fixed table of {addr,data} pairs and issues one SCCB byte write per
// entry through a req/ack handshake. It inserts a settling delay after the soft
// reset, retries failed writes, and reports done or error.
module ov7670_config_seq #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int DELAY_MS       = 10,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       sccb_req,
  output logic [7:0] sccb_addr,
  output logic [7:0] sccb_data,
  input  logic       sccb_ack,
  input  logic       sccb_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] reg_index
);

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  localparam int unsigned DELAY_CYCLES = (DELAY_MS * CLK_FREQ) / 1000;
  // The FETCH cycle that decodes the delay marker counts as the first delay
  // cycle, so the DELAY state itself runs DELAY_CYCLES-1 cycles.
  localparam logic [31:0] DELAY_END  = (DELAY_CYCLES > 1) ? 32'(DELAY_CYCLES - 2) : 32'd0;
  // tcnt holds the number of earlier req-high cycles; the attempt fails on
  // the cycle that is the TIMEOUT_CYCLES-th one.
  localparam logic [31:0] TIMEOUT_M1 = (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [7:0]  RETRY_LIM  = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  retry_cnt;
  logic [31:0] tcnt;
  logic [31:0] dcnt;
  logic        gap;        // first REQ cycle of a retry keeps sccb_req low
  logic [15:0] entry;
  logic        wait_fail;
  logic        delay_end;
  logic        can_retry;

  function automatic logic [15:0] table_entry(input logic [7:0] idx);
    logic [15:0] e;
    case (idx)
      8'd0:    e = 16'h1280;  // COM7 soft reset
      8'd1:    e = 16'hFFF0;  // settle after soft reset
      8'd2:    e = 16'h1204;
      8'd3:    e = 16'h1101;
      8'd4:    e = 16'h40D0;
      8'd5:    e = 16'h8C00;
      8'd6:    e = 16'h3A04;
      default: e = 16'hFFFF;  // end marker; anything past the table also ends it
    endcase
    return e;
  endfunction

  assign entry     = table_entry(reg_index);
  assign wait_fail = sccb_nack || (tcnt >= TIMEOUT_M1);
  assign delay_end = (dcnt >= DELAY_END);
  assign can_retry = (retry_cnt < RETRY_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx = state;
    sccb_req = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (entry == ENTRY_END)        state_nx = S_DONE;
        else if (entry == ENTRY_DELAY) state_nx = S_DELAY;
        else                           state_nx = S_REQ;
      end
      S_REQ: begin
        sccb_req = !gap;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        sccb_req = 1'b1;
        if (wait_fail)     state_nx = can_retry ? S_REQ : S_ERROR;
        else if (sccb_ack) state_nx = S_FETCH;
      end
      S_DELAY: begin
        if (delay_end) state_nx = S_FETCH;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nx = S_FETCH;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_nx = S_FETCH;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Table index, latched write, retry/timeout/delay counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_index <= '0;
      sccb_addr <= '0;
      sccb_data <= '0;
      retry_cnt <= '0;
      tcnt      <= '0;
      dcnt      <= '0;
      gap       <= 1'b0;
    end else begin
      if (!sccb_req)        tcnt <= '0;
      else if (tcnt != '1)  tcnt <= tcnt + 32'd1;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) reg_index <= '0;
        end
        S_FETCH: begin
          if (entry == ENTRY_DELAY) begin
            dcnt <= '0;
          end else if (entry != ENTRY_END) begin
            sccb_addr <= entry[15:8];
            sccb_data <= entry[7:0];
            retry_cnt <= '0;
            gap       <= 1'b0;
          end
        end
        S_REQ: begin
          gap <= 1'b0;
        end
        S_WAIT: begin
          if (wait_fail) begin
            if (can_retry) begin
              retry_cnt <= retry_cnt + 8'd1;
              gap       <= 1'b1;
            end
          end else if (sccb_ack) begin
            reg_index <= reg_index + 8'd1;
          end
        end
        S_DELAY: begin
          if (delay_end) reg_index <= reg_index + 8'd1;
          else           dcnt      <= dcnt + 32'd1;
        end
        default: begin
          dcnt <= dcnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: SCCB responder, write monitor and scoreboard.
module tb_ov7670_config_seq;

  localparam int CLK_FREQ       = 100_000;
  localparam int DELAY_MS       = 10;
  localparam int MAX_RETRY      = 3;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int DELAY_GAP      = DELAY_MS * CLK_FREQ / 1000 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sccb_ack = 1'b0;
  logic       sccb_nack = 1'b0;
  logic       sccb_req, busy, done, error;
  logic [7:0] sccb_addr, sccb_data, reg_index;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          gap_q[$];
  int          len_q[$];
  int          rise_q[$];

  logic [15:0] nack_key = 16'h0000;
  logic [15:0] silent_key = 16'h0000;
  logic [15:0] both_key = 16'h0000;
  int          nack_left = 0;
  int          both_left = 0;

  logic [15:0] golden [6] = '{16'h1280, 16'h1204, 16'h1101, 16'h40D0, 16'h8C00, 16'h3A04};

  ov7670_config_seq #(
    .CLK_FREQ(CLK_FREQ), .DELAY_MS(DELAY_MS),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sccb_req(sccb_req), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_ack(sccb_ack), .sccb_nack(sccb_nack),
    .busy(busy), .done(done), .error(error), .reg_index(reg_index)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Responder and monitor: records each request, the low run before it and
  // the length of each high run; answers on the third high cycle.
  initial begin : responder
    int hc;
    int lc;
    logic [15:0] key;
    hc = 0;
    lc = 0;
    forever begin
      @(negedge clk);
      sccb_ack  = 1'b0;
      sccb_nack = 1'b0;
      key = {sccb_addr, sccb_data};
      if (!rst_n) begin
        hc = 0;
        lc = 0;
      end else if (sccb_req) begin
        if (hc == 0) begin
          obs_q.push_back(key);
          gap_q.push_back(lc);
          rise_q.push_back(cyc);
          lc = 0;
        end
        hc++;
        if (hc == 3 && key != silent_key) begin
          if (key == both_key && both_left > 0) begin
            sccb_ack = 1'b1; sccb_nack = 1'b1; both_left--;
          end else if (key == nack_key && nack_left > 0) begin
            sccb_nack = 1'b1; nack_left--;
          end else begin
            sccb_ack = 1'b1;
          end
        end
      end else begin
        if (hc > 0) len_q.push_back(hc);
        hc = 0;
        lc++;
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); gap_q.delete(); len_q.delete(); rise_q.delete();
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_end(input int lim, output bit to);
    to = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done || error) begin
        to = 1'b0;
        break;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sccb_req, busy, done, error} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 0000", {sccb_req, busy, done, error});
    end
    n_cmp++;
    if ({sccb_addr, sccb_data, reg_index} !== 24'h0) begin
      n_err++; $display("FAIL reset_regs: got %h required 000000", {sccb_addr, sccb_data, reg_index});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({sccb_req, busy, done, error} !== 4'b0) begin
      n_err++; $display("FAIL idle_after_reset: got %b required 0000", {sccb_req, busy, done, error});
    end
  endtask

  task automatic test_full_sequence();
    int s; bit to; logic [15:0] e, o; int g, r;
    clear_queues();
    for (int i = 0; i < 6; i++) exp_q.push_back(golden[i]);
    pulse_start(s);
    wait_end(3000, to);
    n_cmp++;
    if (to !== 1'b0) begin n_err++; $display("FAIL full_timeout: no done/error got %b required 0", to); end
    n_cmp++;
    if (obs_q.size() != 6) begin n_err++; $display("FAIL full_count: got %0d required 6", obs_q.size()); end
    g = (gap_q.size() > 1) ? gap_q[1] : -1;
    r = (rise_q.size() > 0) ? rise_q[0] - s : -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL full_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL full_write: got %h required %h", o, e); end
      end
    end
    n_cmp++;
    if (g != DELAY_GAP) begin n_err++; $display("FAIL delay_gap: got %0d required %0d", g, DELAY_GAP); end
    n_cmp++;
    if (r != 1) begin n_err++; $display("FAIL first_req_latency: got %0d required 1", r); end
    n_cmp++;
    if ({done, busy, error} !== 3'b100) begin
      n_err++; $display("FAIL full_status: done/busy/error got %b required 100", {done, busy, error});
    end
  endtask

  task automatic test_nack_retry();
    int s; bit to; logic [15:0] e, o; int g4, g5;
    clear_queues();
    nack_key = 16'h40D0; nack_left = 2;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(golden[i]);
      if (i == 3) begin exp_q.push_back(golden[3]); exp_q.push_back(golden[3]); end
    end
    pulse_start(s);
    wait_end(3000, to);
    g4 = (gap_q.size() > 5) ? gap_q[4] : -1;
    g5 = (gap_q.size() > 5) ? gap_q[5] : -1;
    n_cmp++;
    if (obs_q.size() != 8) begin n_err++; $display("FAIL nack_count: got %0d required 8", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL nack_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL nack_write: got %h required %h", o, e); end
      end
    end
    n_cmp++;
    if (g4 != 1 || g5 != 1) begin n_err++; $display("FAIL nack_low_gap: got %0d,%0d required 1,1", g4, g5); end
    n_cmp++;
    if ({to, done, error} !== 3'b010) begin
      n_err++; $display("FAIL nack_status: timeout/done/error got %b required 010", {to, done, error});
    end
    nack_key = 16'h0000;
  endtask

  task automatic test_error_exhaust();
    int s; bit to; logic [15:0] e, o;
    clear_queues();
    nack_key = 16'h1101; nack_left = 4;
    exp_q.push_back(golden[0]); exp_q.push_back(golden[1]);
    for (int i = 0; i < 4; i++) exp_q.push_back(golden[2]);
    pulse_start(s);
    wait_end(3000, to);
    n_cmp++;
    if ({to, error, done, busy} !== 4'b0100) begin
      n_err++; $display("FAIL err_status: timeout/error/done/busy got %b required 0100", {to, error, done, busy});
    end
    n_cmp++;
    if (reg_index !== 8'd3) begin n_err++; $display("FAIL err_index: got %0d required 3", reg_index); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL err_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL err_write: got %h required %h", o, e); end
      end
    end
    repeat (100) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || reg_index !== 8'd3) begin
      n_err++; $display("FAIL err_quiet: extra requests %0d index %0d required 0 and 3", obs_q.size(), reg_index);
    end
    nack_key = 16'h0000;
    clear_queues();
    for (int i = 0; i < 6; i++) exp_q.push_back(golden[i]);
    pulse_start(s);
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b required 0", error); end
    wait_end(3000, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL restart_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL restart_write: got %h required %h", o, e); end
      end
    end
    n_cmp++;
    if ({to, done, error} !== 3'b010) begin
      n_err++; $display("FAIL restart_status: timeout/done/error got %b required 010", {to, done, error});
    end
  endtask

  task automatic test_timeout();
    int s; bit to; logic [15:0] e, o; int l;
    clear_queues();
    silent_key = 16'h1204;
    exp_q.push_back(golden[0]);
    for (int i = 0; i < 4; i++) exp_q.push_back(golden[1]);
    pulse_start(s);
    wait_end(3000, to);
    n_cmp++;
    if ({to, error, done} !== 3'b010) begin
      n_err++; $display("FAIL tmo_status: timeout/error/done got %b required 010", {to, error, done});
    end
    n_cmp++;
    if (reg_index !== 8'd2) begin n_err++; $display("FAIL tmo_index: got %0d required 2", reg_index); end
    for (int i = 1; i < 5; i++) begin
      l = (len_q.size() > i) ? len_q[i] : -1;
      n_cmp++;
      if (l != TIMEOUT_CYCLES) begin
        n_err++; $display("FAIL tmo_req_len[%0d]: got %0d required %0d", i, l, TIMEOUT_CYCLES);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL tmo_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL tmo_write: got %h required %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL tmo_extra: got %0d required 0", obs_q.size()); end
    silent_key = 16'h0000;
  endtask

  task automatic test_start_in_wait();
    int s; bit to; bit found; logic busy_at; logic [15:0] e, o; int g;
    clear_queues();
    both_key = 16'h8C00; both_left = 1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(golden[i]);
      if (i == 4) exp_q.push_back(golden[4]);
    end
    pulse_start(s);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (sccb_req && sccb_addr == 8'h11) found = 1'b1;
    end
    @(negedge clk);
    start = 1'b1;
    busy_at = busy;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({found, busy_at} !== 2'b11) begin
      n_err++; $display("FAIL wait_start_setup: found/busy got %b required 11", {found, busy_at});
    end
    wait_end(3000, to);
    g = (gap_q.size() > 5) ? gap_q[5] : -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL wait_start_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL wait_start_write: got %h required %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL wait_start_extra: got %0d required 0", obs_q.size()); end
    n_cmp++;
    if (g != 1) begin n_err++; $display("FAIL both_retry_gap: got %0d required 1", g); end
    n_cmp++;
    if ({to, done, error} !== 3'b010) begin
      n_err++; $display("FAIL wait_start_status: timeout/done/error got %b required 010", {to, done, error});
    end
    both_key = 16'h0000;
  endtask

  task automatic test_reset_midwrite();
    int s; bit to; bit found; int hits; logic [15:0] e, o;
    clear_queues();
    pulse_start(s);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (sccb_req && sccb_addr == 8'h8C) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin n_err++; $display("FAIL rst_setup: entry 5 request got %b required 1", found); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sccb_req, busy, done, error} !== 4'b0) begin
      n_err++; $display("FAIL rst_async_ctrl: got %b required 0000", {sccb_req, busy, done, error});
    end
    n_cmp++;
    if ({sccb_addr, sccb_data, reg_index} !== 24'h0) begin
      n_err++; $display("FAIL rst_async_regs: got %h required 000000", {sccb_addr, sccb_data, reg_index});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (sccb_req || busy || done || error) hits++;
    end
    n_cmp++;
    if (hits != 0 || obs_q.size() != 0) begin
      n_err++; $display("FAIL rst_idle: active cycles %0d requests %0d required 0 and 0", hits, obs_q.size());
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(golden[i]);
    pulse_start(s);
    wait_end(3000, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL rst_rerun_write: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL rst_rerun_write: got %h required %h", o, e); end
      end
    end
    n_cmp++;
    if ({to, done, busy} !== 3'b010) begin
      n_err++; $display("FAIL rst_rerun_status: timeout/done/busy got %b required 010", {to, done, busy});
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_nack_retry();
    test_error_exhaust();
    test_timeout();
    test_start_in_wait();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
